// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM address arbiter: FSM state encoding,
// default widths and a one-hot to index conversion.
package ram_arb_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_LEN_W  = 8;
    localparam int MAX_CH     = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    function automatic int onehot2idx(input logic [MAX_CH-1:0] oh);
        int idx;
        idx = 0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter: round-robin from ptr by default, or fixed
// lowest-index priority when RAM_ARB_FIXED_PRIO_EN is defined (ptr ignored).
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] gnt
);

    function automatic logic [NUM_CH-1:0] lowest_set(input logic [NUM_CH-1:0] v);
        return v & (~v + NUM_CH'(1));
    endfunction

`ifdef RAM_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ^ptr;

    always_comb begin
        gnt = lowest_set(req);
    end
`else
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] req_hi;

    // Requests at or above the pointer win first; otherwise wrap to the lowest.
    always_comb begin
        mask = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            mask[c] = (CH_W'(c) >= ptr);
        end
        req_hi = req & mask;
        gnt    = (|req_hi) ? lowest_set(req_hi) : lowest_set(req);
    end
`endif

endmodule

// File: rtl/ram_addr_arbiter.sv
// Shares one RAM address port among NUM_CH requesters, issuing a registered
// burst of sequential addresses per grant. RAM_ARB_FIXED_PRIO_EN selects fixed priority.
module ram_addr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int  NUM_CH = DEF_NUM_CH,
    parameter int  ADDR_W = DEF_ADDR_W,
    parameter int  LEN_W  = DEF_LEN_W,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic [NUM_CH-1:0]        Req,
    input  logic [NUM_CH*ADDR_W-1:0] BaseAddr,
    input  logic [NUM_CH*LEN_W-1:0]  BurstLen,
    input  logic                     RamReady,
    output logic [NUM_CH-1:0]        Grant,
    output logic [NUM_CH-1:0]        Done,
    output logic                     RamEn,
    output logic [ADDR_W-1:0]        AddressToRAM,
    output logic [CH_W-1:0]          ActiveCh
);

    arb_state_e        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [NUM_CH-1:0] grant_q, grant_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              ram_en_q, ram_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [CH_W-1:0]   ach_q, ach_d;

    logic [NUM_CH-1:0] arb_gnt;
    logic [MAX_CH-1:0] gnt_ext;
    logic [CH_W-1:0]   win_idx;
    logic [ADDR_W-1:0] base_sel;
    logic [LEN_W-1:0]  len_sel;
    logic              accept;
    logic              owner_req;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req (Req),
        .ptr (ptr_q),
        .gnt (arb_gnt)
    );

    // Winner's index and its base/length, picked straight from the one-hot grant.
    always_comb begin
        gnt_ext              = '0;
        gnt_ext[NUM_CH-1:0]  = arb_gnt;
        win_idx              = CH_W'(onehot2idx(gnt_ext));
        base_sel             = '0;
        len_sel              = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (arb_gnt[i]) begin
                base_sel = BaseAddr[i*ADDR_W +: ADDR_W];
                len_sel  = BurstLen[i*LEN_W +: LEN_W];
            end
        end
    end

    assign accept    = ram_en_q & RamReady;
    assign owner_req = |(Req & grant_q);

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        done_d   = '0;
        ram_en_d = ram_en_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        ach_d    = ach_q;

        case (state_q)
            IDLE: begin
                grant_d  = '0;
                ram_en_d = 1'b0;
                ach_d    = '0;
                if (|Req) begin
                    grant_d = arb_gnt;
                    ach_d   = win_idx;
                    addr_d  = base_sel;
                    rem_d   = len_sel;
`ifdef RAM_ARB_FIXED_PRIO_EN
                    ptr_d   = '0;
`else
                    ptr_d   = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + CH_W'(1);
`endif
                    if (len_sel == '0) begin
                        state_d = DONE;
                        done_d  = arb_gnt;
                    end else begin
                        state_d  = BURST;
                        ram_en_d = 1'b1;
                    end
                end
            end

            BURST: begin
                // An owner dropping its request wins over a simultaneous final beat.
                if (!owner_req) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    ram_en_d = 1'b0;
                    ach_d    = '0;
                end else if (accept) begin
                    if (rem_q == LEN_W'(1)) begin
                        state_d  = DONE;
                        done_d   = grant_q;
                        ram_en_d = 1'b0;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                        rem_d  = rem_q - LEN_W'(1);
                    end
                end
            end

            DONE: begin
                state_d  = IDLE;
                grant_d  = '0;
                ram_en_d = 1'b0;
                ach_d    = '0;
            end

            default: begin
                state_d  = IDLE;
                grant_d  = '0;
                ram_en_d = 1'b0;
                ach_d    = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            grant_q  <= '0;
            done_q   <= '0;
            ram_en_q <= 1'b0;
            addr_q   <= '0;
            rem_q    <= '0;
            ach_q    <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
            ram_en_q <= ram_en_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            ach_q    <= ach_d;
        end
    end

    assign Grant        = grant_q;
    assign Done         = done_q;
    assign RamEn        = ram_en_q;
    assign AddressToRAM = addr_q;
    assign ActiveCh     = ach_q;

endmodule

// File: tb/tb_ram_addr_arbiter.sv
// Directed bench for ram_addr_arbiter with a scoreboard of expected beats and
// Done pulses popped by a negedge monitor.
module tb_ram_addr_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 16;
    localparam int LW  = 8;

    logic              Clk;
    logic              Rst_n;
    logic [NCH-1:0]    Req;
    logic [NCH*AW-1:0] BaseAddr;
    logic [NCH*LW-1:0] BurstLen;
    logic              RamReady;
    logic [NCH-1:0]    Grant;
    logic [NCH-1:0]    Done;
    logic              RamEn;
    logic [AW-1:0]     AddressToRAM;
    logic [1:0]        ActiveCh;

    ram_addr_arbiter #(
        .NUM_CH (NCH),
        .ADDR_W (AW),
        .LEN_W  (LW)
    ) dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
        .Req          (Req),
        .BaseAddr     (BaseAddr),
        .BurstLen     (BurstLen),
        .RamReady     (RamReady),
        .Grant        (Grant),
        .Done         (Done),
        .RamEn        (RamEn),
        .AddressToRAM (AddressToRAM),
        .ActiveCh     (ActiveCh)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic          is_done;
        logic [1:0]    ch;
        logic [AW-1:0] addr;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  pass_cnt  = 0;
    int  fail_cnt  = 0;
    int  total_cnt = 0;
    bit  mon_en    = 1'b0;
    int  ptr_m     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference winner selection, advancing the model pointer on every grant.
    function automatic int pick(input logic [NCH-1:0] r);
        int w;
        w = 0;
`ifdef RAM_ARB_FIXED_PRIO_EN
        for (int i = NCH - 1; i >= 0; i--) if (r[i]) w = i;
        ptr_m = 0;
`else
        for (int i = NCH - 1; i >= 0; i--) if (r[(ptr_m + i) % NCH]) w = (ptr_m + i) % NCH;
        ptr_m = (w + 1) % NCH;
`endif
        return w;
    endfunction

    task automatic push_burst(input int ch, input logic [AW-1:0] base, input int len, input bit with_done);
        ev_t e;
        for (int i = 0; i < len; i++) begin
            e.is_done = 1'b0;
            e.ch      = 2'(ch);
            e.addr    = base + AW'(i);
            sb.push_back(e);
        end
        if (with_done) begin
            e.is_done = 1'b1;
            e.ch      = 2'(ch);
            e.addr    = '0;
            sb.push_back(e);
        end
    endtask

    task automatic set_ch(input int ch, input logic [AW-1:0] base, input logic [LW-1:0] len);
        BaseAddr[ch*AW +: AW] = base;
        BurstLen[ch*LW +: LW] = len;
    endtask

    task automatic wait_empty(input string tag);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(posedge Clk); #1;
        end
        chk(tag, 32'(sb.size()), 32'd0);
    endtask

    always @(negedge Clk) begin
        if (mon_en && Rst_n) begin
            if (RamEn && RamReady) begin
                chk("beat_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("beat_kind", 32'(mon_e.is_done), 32'd0);
                    chk("beat_addr", 32'(AddressToRAM), 32'(mon_e.addr));
                    chk("beat_ch", 32'(ActiveCh), 32'(mon_e.ch));
                    chk("beat_grant", 32'(Grant), 32'(4'b0001 << mon_e.ch));
                end
            end
            if (|Done) begin
                chk("done_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    chk("done_kind", 32'(mon_e.is_done), 32'd1);
                    chk("done_vec", 32'(Done), 32'(4'b0001 << mon_e.ch));
                    chk("done_grant", 32'(Grant), 32'(4'b0001 << mon_e.ch));
                    chk("done_ramen", 32'(RamEn), 32'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int w;
        Rst_n    = 1'b0;
        Req      = '0;
        BaseAddr = '0;
        BurstLen = '0;
        RamReady = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        chk("rst_grant", 32'(Grant), 32'd0);
        chk("rst_done", 32'(Done), 32'd0);
        chk("rst_ramen", 32'(RamEn), 32'd0);
        chk("rst_addr", 32'(AddressToRAM), 32'd0);
        chk("rst_ach", 32'(ActiveCh), 32'd0);
        Rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge Clk); #1;

        // Single burst on ch2
        set_ch(2, 16'h0100, 8'd4);
        RamReady = 1'b1;
        w = pick(4'b0100);
        push_burst(w, 16'h0100, 4, 1'b1);
        Req = 4'b0100;
        @(posedge Clk);
        @(negedge Clk);
        chk("single_lat_ramen", 32'(RamEn), 32'd1);
        chk("single_lat_addr", 32'(AddressToRAM), 32'h0100);
        chk("single_lat_grant", 32'(Grant), 32'b0100);
        chk("single_lat_ach", 32'(ActiveCh), 32'd2);
        wait_empty("single_drain");
        Req = '0;
        @(posedge Clk); #1;

        // Backpressure on ch1
        set_ch(1, 16'h0100, 8'd3);
        w = pick(4'b0010);
        push_burst(w, 16'h0100, 3, 1'b1);
        Req = 4'b0010;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        RamReady = 1'b0;
        chk("bp_hold0", 32'(AddressToRAM), 32'h0101);
        @(posedge Clk); #1;
        chk("bp_hold1", 32'(AddressToRAM), 32'h0101);
        @(posedge Clk); #1;
        RamReady = 1'b1;
        chk("bp_hold2", 32'(AddressToRAM), 32'h0101);
        chk("bp_ramen", 32'(RamEn), 32'd1);
        wait_empty("bp_drain");
        Req = '0;
        @(posedge Clk); #1;

        // Address wrap on ch3
        set_ch(3, 16'hFFFE, 8'd4);
        w = pick(4'b1000);
        push_burst(w, 16'hFFFE, 4, 1'b1);
        Req = 4'b1000;
        wait_empty("wrap_drain");
        Req = '0;
        @(posedge Clk); #1;

        // All four requesting, one beat each
        for (int c = 0; c < NCH; c++) set_ch(c, AW'(32'h1000 * (c + 1)), 8'd1);
        for (int k = 0; k < 5; k++) begin
            w = pick(4'b1111);
            push_burst(w, AW'(32'h1000 * (w + 1)), 1, 1'b1);
        end
        Req = 4'b1111;
        wait_empty("arb_drain");
        Req = '0;
        @(posedge Clk); #1;

        // Abort on ch1 after two beats
        set_ch(1, 16'h0200, 8'd8);
        w = pick(4'b0010);
        push_burst(w, 16'h0200, 2, 1'b0);
        Req = 4'b0010;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Req = '0;
        @(posedge Clk); #1;
        chk("abort_grant", 32'(Grant), 32'd0);
        chk("abort_ramen", 32'(RamEn), 32'd0);
        chk("abort_ach", 32'(ActiveCh), 32'd0);
        repeat (4) @(posedge Clk);
        #1;
        wait_empty("abort_drain");

        // Zero-length burst on ch3
        set_ch(3, 16'h0300, 8'd0);
        w = pick(4'b1000);
        push_burst(w, 16'h0300, 0, 1'b1);
        Req = 4'b1000;
        @(posedge Clk);
        @(negedge Clk);
        chk("zero_grant", 32'(Grant), 32'b1000);
        chk("zero_done", 32'(Done), 32'b1000);
        chk("zero_ramen", 32'(RamEn), 32'd0);
        wait_empty("zero_drain");
        Req = '0;
        @(posedge Clk); #1;
        chk("zero_idle_grant", 32'(Grant), 32'd0);

        // Asynchronous reset in the middle of a burst
        mon_en = 1'b0;
        set_ch(0, 16'h0400, 8'd8);
        Req = 4'b0001;
        repeat (3) @(posedge Clk);
        #3;
        chk("mid_pre_ramen", 32'(RamEn), 32'd1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_grant", 32'(Grant), 32'd0);
        chk("mid_rst_ramen", 32'(RamEn), 32'd0);
        chk("mid_rst_addr", 32'(AddressToRAM), 32'd0);
        Req = '0;
        @(negedge Clk);
        Rst_n = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        chk("post_rst_grant", 32'(Grant), 32'd0);
        chk("post_rst_ramen", 32'(RamEn), 32'd0);
        chk("post_rst_done", 32'(Done), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
